// File: rtl/mvu_outwb.sv
// MVU output write-back: buffers quantizer words and writes them along a 3-D strided walk.
// Optional sticky error output when compiled with MVU_OUTWB_ERR_EN.
module mvu_outwb #(
  parameter int N       = 64,
  parameter int BDBANKA = 15,
  parameter int DEPTH   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [BDBANKA-1:0] obaseaddr,
  input  logic [BDBANKA-1:0] ostride_0,
  input  logic [BDBANKA-1:0] ostride_1,
  input  logic [BDBANKA-1:0] ostride_2,
  input  logic [14:0]        olength_0,
  input  logic [14:0]        olength_1,
  input  logic [14:0]        olength_2,
  input  logic               in_valid,
  input  logic [N-1:0]       in_word,
  output logic               in_ready,
  output logic               wrd_en,
  input  logic               wrd_grnt,
  output logic [BDBANKA-1:0] wrd_addr,
  output logic [N-1:0]       wrd_word,
  output logic               busy,
`ifdef MVU_OUTWB_ERR_EN
  output logic               err,
`endif
  output logic               done
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_q, state_d;

  logic [BDBANKA-1:0] s0_q, s1_q, s2_q;
  logic [14:0]        l0_q, l1_q, l2_q;
  logic [14:0]        c0_q, c1_q, c2_q;
  logic [14:0]        o0_q, o1_q, o2_q;
  logic               in_last_q;
  logic [BDBANKA-1:0] addr_q, row_q, plane_q;
  logic [N-1:0]       mem_q [DEPTH];
  logic [AW:0]        wr_ptr_q, rd_ptr_q;

  logic run, full, empty, push, pop;
  logic in_end, out_end, last_pop;

  assign run   = (state_q == RUN);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign in_end  = (c0_q == l0_q) && (c1_q == l1_q) &&
                   (c2_q == l2_q);
  assign out_end = (o0_q == l0_q) && (o1_q == l1_q) &&
                   (o2_q == l2_q);

  assign push     = in_valid && in_ready;
  assign pop      = wrd_en && wrd_grnt;
  assign last_pop = pop && out_end;

  assign wrd_addr = addr_q;
  assign wrd_word = mem_q[rd_ptr_q[AW-1:0]];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d  = state_q;
    busy     = run;
    done     = (state_q == DONE);
    in_ready = run && !full && !in_last_q;
    wrd_en   = run && !empty;
    if (start) begin
      state_d = RUN;
    end else begin
      unique case (state_q)
        IDLE:    state_d = IDLE;
        RUN:     if (last_pop) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push && !start) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_word;
    end
  end

  // Config latch, FIFO pointers and input-side word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q <= '0; s1_q <= '0; s2_q <= '0;
      l0_q <= '0; l1_q <= '0; l2_q <= '0;
      c0_q <= '0; c1_q <= '0; c2_q <= '0;
      in_last_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else if (start) begin
      s0_q <= ostride_0; s1_q <= ostride_1;
      s2_q <= ostride_2;
      l0_q <= olength_0; l1_q <= olength_1;
      l2_q <= olength_2;
      c0_q <= '0; c1_q <= '0; c2_q <= '0;
      in_last_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
        if (in_end) begin
          in_last_q <= 1'b1;
        end else if (c0_q != l0_q) begin
          c0_q <= c0_q + 15'd1;
        end else begin
          c0_q <= '0;
          if (c1_q != l1_q) begin
            c1_q <= c1_q + 15'd1;
          end else begin
            c1_q <= '0;
            c2_q <= c2_q + 15'd1;
          end
        end
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Output index counters and incremental address walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o0_q <= '0; o1_q <= '0; o2_q <= '0;
      addr_q  <= '0;
      row_q   <= '0;
      plane_q <= '0;
    end else if (start) begin
      o0_q <= '0; o1_q <= '0; o2_q <= '0;
      addr_q  <= obaseaddr;
      row_q   <= obaseaddr;
      plane_q <= obaseaddr;
    end else if (pop && !out_end) begin
      if (o0_q != l0_q) begin
        o0_q   <= o0_q + 15'd1;
        addr_q <= addr_q + s0_q;
      end else if (o1_q != l1_q) begin
        o0_q   <= '0;
        o1_q   <= o1_q + 15'd1;
        row_q  <= row_q + s1_q;
        addr_q <= row_q + s1_q;
      end else begin
        o0_q    <= '0;
        o1_q    <= '0;
        o2_q    <= o2_q + 15'd1;
        plane_q <= plane_q + s2_q;
        row_q   <= plane_q + s2_q;
        addr_q  <= plane_q + s2_q;
      end
    end
  end

`ifdef MVU_OUTWB_ERR_EN
  // Sticky protocol error; a restart over a running job flags itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (start) begin
      err <= run;
    end else if (in_valid &&
                 ((state_q == IDLE) || (run && in_last_q))) begin
      err <= 1'b1;
    end
  end
`endif

endmodule
